pwm_carrier_sched: RTL and testbench
====================================

// Module: pwm_carrier_sched
// PURPOSE
// - Generates the shared triangular carrier and schedules compare-value updates for N_CH compare_16bits-style comparators.
// - Write-side handshake loads a shadow register; the active compare is updated only at carrier valley, so no mid-period glitches.
// - Sequences pwm_onoff start/stop so channels turn on and off at period boundaries.
// - Sits between the PS/AXI register bank and the per-channel comparators.
// PARAMETERS
// - N_CH     default 3    number of compare channels
// - CNT_W    default 16   carrier/compare width in bits
// PORTS
// - clk          in   1          system clock
// - rstn         in   1          synchronous reset, active-low
// - enable       in   1          run request; level-sensitive
// - period       in   CNT_W      carrier peak value; sampled at each valley
// - cmp_wr_valid in   1          new compare set offered
// - cmp_wr_ready out  1          shadow free; write accepted when valid&ready
// - cmp_wr_data  in   N_CH*CNT_W compare set; ch k at [k*CNT_W +: CNT_W]
// - carrier      out  CNT_W      triangular carrier to comparators
// - compare      out  N_CH*CNT_W active compare values to comparators
// - pwm_onoff    out  N_CH       per-channel output enable (all bits equal)
// - update_evt   out  1          1-cycle pulse: active compare reloaded this cycle
// - cnt_up       out  1          1 = carrier counting up
// BEHAVIOUR
// - Reset (rstn=0 at clk edge): carrier=0, compare=0, pwm_onoff=0, update_evt=0, cnt_up=1, cmp_wr_ready=1, shadow pending=0, state=IDLE.
// - FSM states: IDLE, RUN, STOP.
//   - IDLE: carrier held 0, pwm_onoff=0; enable=1 -> RUN next cycle.
//   - RUN: carrier counts; pwm_onoff=all 1; enable=0 -> STOP.
//   - STOP: carrier keeps counting; at next valley -> IDLE, pwm_onoff=0 in the same cycle carrier reads 0; enable=1 in STOP -> back to RUN.
// - Carrier: up by 1 to period_latched, then down by 1 to 0, repeat; peak and valley each held exactly 1 cycle. Full period = 2*period cycles.
// - period latched at IDLE->RUN and at every valley; a change mid-period has no effect until the next valley.
// - period=0: carrier stays 0; every cycle is a valley.
// - Shadow handshake: cmp_wr_ready = ~pending. On valid&ready: shadow<=data, pending<=1.
// - Update point: the cycle carrier transitions to 0 (valley), and the IDLE->RUN cycle:
//   - if pending, compare<=shadow, pending<=0, update_evt=1;
//   - a write accepted in that same cycle goes to shadow and is applied at the following valley.
// - Clamp: each shadow channel value > period_latched is loaded as period_latched (never exceeds carrier peak).
// - Latency: write accepted at cycle t -> visible on compare at next valley (<= 2*period+1 cycles).
// - Reset mid-run: immediate return to reset values; pending shadow discarded.
// - Arithmetic: carrier is unsigned CNT_W; never wraps (direction reverses at 0 and period_latched).
// CONFIGURATION
// - Macro PWM_PEAK_UPDATE_EN:
//   - defined: the peak (carrier==period_latched) is also an update point (double-update mode), with identical clamp/pending/update_evt rules;
//   - undefined: valley only.
// - STOP->IDLE always occurs at valley in both modes.
// TESTING
// 1. Reset, enable=1, period=4 -> carrier 0,1,2,3,4,3,2,1,0,1...; cnt_up=0 from the cycle carrier reaches 4 until carrier reaches 0; pwm_onoff=111 from cycle after enable.
// 2. RUN period=4, write {3,2,1} at carrier=2 rising -> ready=0 next cycle, compare unchanged until valley, then compare={3,2,1}, update_evt=1 one cycle, ready=1.
// 3. Write {9,9,9} with period=4 -> compare={4,4,4} at valley (clamp).
// 4. Two writes back-to-back -> second stalls (ready=0) until valley; second applied at the following valley.
// 5. enable=0 at carrier=3 rising -> carrier continues 4,3,2,1,0; pwm_onoff=000 when carrier=0; FSM IDLE, carrier held 0.
// 6. With PWM_PEAK_UPDATE_EN, write at carrier=1 rising -> update_evt and new compare at carrier=4; without it at carrier=0.

Source files
------------

// File: rtl/pwm_carrier_sched.sv
// ----------------------------------------------------------------------------
// pwm_carrier_sched
// Shared triangular carrier generator and compare-value update scheduler for
// N_CH comparator channels. New compare sets arrive through a valid/ready
// handshake into a single shadow register. The shadow is copied into the
// active compare set only at carrier update points, so a comparator never
// sees a mid-period change. Channel enable (pwm_onoff) is sequenced so that
// outputs start and stop on period boundaries.
//
// Optional feature: define PWM_PEAK_UPDATE_EN to also treat the carrier
// peak as an update point (double-update mode). With the macro undefined
// only the valley (and the IDLE->RUN cycle) reloads the compare set.
//
// Ports
//   clk          in   system clock
//   rstn         in   synchronous reset, active-low
//   enable       in   run request (level)
//   period       in   carrier peak value, latched at start and each valley
//   cmp_wr_valid in   new compare set offered
//   cmp_wr_ready out  shadow free; write accepted when valid & ready
//   cmp_wr_data  in   compare set, channel k at [k*CNT_W +: CNT_W]
//   carrier      out  triangular carrier
//   compare      out  active compare values
//   pwm_onoff    out  per-channel output enable (all bits equal)
//   update_evt   out  one-cycle pulse when the active compare was reloaded
//   cnt_up       out  1 while the carrier is counting up
// ----------------------------------------------------------------------------
module pwm_carrier_sched #(
    parameter int N_CH  = 3,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      period,
    input  logic                  cmp_wr_valid,
    output logic                  cmp_wr_ready,
    input  logic [N_CH*CNT_W-1:0] cmp_wr_data,
    output logic [CNT_W-1:0]      carrier,
    output logic [N_CH*CNT_W-1:0] compare,
    output logic [N_CH-1:0]       pwm_onoff,
    output logic                  update_evt,
    output logic                  cnt_up
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_carrier;
    logic                   r_cnt_up;
    logic [CNT_W-1:0]       r_period;
    logic [N_CH*CNT_W-1:0]  r_shadow;
    logic                   r_pending;
    logic [N_CH*CNT_W-1:0]  r_compare;
    logic                   r_update_evt;
    logic [N_CH-1:0]        r_onoff;

    logic                   w_running;
    logic                   w_start;
    logic                   w_to_valley;
    logic                   w_to_peak;
    logic                   w_upd_pt;
    logic                   w_accept;
    logic [CNT_W-1:0]       w_period_nxt;
    logic [CNT_W-1:0]       w_carrier_nxt;
    logic                   w_cnt_up_nxt;
    logic [N_CH*CNT_W-1:0]  w_clamped;

    // Limit a compare value so it never exceeds the carrier peak.
    function automatic logic [CNT_W-1:0] clamp_to_peak(
        input logic [CNT_W-1:0] val,
        input logic [CNT_W-1:0] peak
    );
        logic [CNT_W-1:0] res;
        if (val > peak) begin
            res = peak;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Carrier stepping, valley/peak detection and update-point selection.
    always_comb begin
        w_running   = (r_state != ST_IDLE);
        w_start     = (r_state == ST_IDLE) && enable;
        // A zero period pins the carrier at 0, so every running cycle is a valley.
        w_to_valley = w_running && ((r_period == '0) ||
                      (!r_cnt_up && (r_carrier == CNT_W'(1))));
        w_to_peak   = w_running && r_cnt_up && (r_period != '0) &&
                      ((r_carrier + CNT_W'(1)) == r_period);
        w_accept    = cmp_wr_valid && !r_pending;

        // The period governing the next half-cycle is captured at start/valley.
        if (w_start || w_to_valley) begin
            w_period_nxt = period;
        end else begin
            w_period_nxt = r_period;
        end

`ifdef PWM_PEAK_UPDATE_EN
        w_upd_pt = w_start || w_to_valley || w_to_peak;
`else
        w_upd_pt = w_start || w_to_valley;
`endif

        if (!w_running) begin
            w_carrier_nxt = '0;
            w_cnt_up_nxt  = 1'b1;
        end else if (r_period == '0) begin
            w_carrier_nxt = '0;
            w_cnt_up_nxt  = 1'b1;
        end else if (r_cnt_up) begin
            w_carrier_nxt = r_carrier + CNT_W'(1);
            w_cnt_up_nxt  = !w_to_peak;
        end else begin
            w_carrier_nxt = r_carrier - CNT_W'(1);
            w_cnt_up_nxt  = w_to_valley;
        end
    end

    // Per-channel clamp of the shadow set against the period that is in force
    // after this update point.
    always_comb begin
        w_clamped = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_clamped[k*CNT_W +: CNT_W] =
                clamp_to_peak(r_shadow[k*CNT_W +: CNT_W], w_period_nxt);
        end
    end

    // Run/stop FSM, carrier registers and shadow/active compare transfer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_carrier    <= '0;
            r_cnt_up     <= 1'b1;
            r_period     <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_compare    <= '0;
            r_update_evt <= 1'b0;
            r_onoff      <= '0;
        end else begin
            r_carrier    <= w_carrier_nxt;
            r_cnt_up     <= w_cnt_up_nxt;
            r_period     <= w_period_nxt;
            r_update_evt <= w_upd_pt && r_pending;

            // Accept needs pending==0, so it never collides with a reload.
            if (w_upd_pt && r_pending) begin
                r_compare <= w_clamped;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_shadow  <= cmp_wr_data;
                r_pending <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                        r_onoff <= '1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_onoff <= '0;
                    end
                end
                ST_RUN: begin
                    r_onoff <= '1;
                    if (!enable) begin
                        r_state <= ST_STOP;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_STOP: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                        r_onoff <= '1;
                    end else if (w_to_valley) begin
                        // Outputs drop in the same cycle the carrier reads 0.
                        r_state <= ST_IDLE;
                        r_onoff <= '0;
                    end else begin
                        r_state <= ST_STOP;
                        r_onoff <= '1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_onoff <= '0;
                end
            endcase
        end
    end

    assign cmp_wr_ready = !r_pending;
    assign carrier      = r_carrier;
    assign compare      = r_compare;
    assign pwm_onoff    = r_onoff;
    assign update_evt   = r_update_evt;
    assign cnt_up       = r_cnt_up;

endmodule

// File: tb/tb_pwm_carrier_sched.sv
// ----------------------------------------------------------------------------
// tb_pwm_carrier_sched
// Directed bench for pwm_carrier_sched (N_CH=3, CNT_W=16). Expected carrier,
// direction and output-enable values are queued ahead of the cycles they
// describe; expected compare sets are queued when a write is accepted and
// retired when update_evt fires.
// ----------------------------------------------------------------------------
module tb_pwm_carrier_sched;

    typedef struct {
        logic [15:0] c;
        logic        up;
        logic [2:0]  on;
    } exp_t;

    typedef struct {
        logic [47:0] cmp;
        logic [15:0] c;
    } upd_t;

`ifdef PWM_PEAK_UPDATE_EN
    localparam logic [15:0] PK_C = 16'd4;
`else
    localparam logic [15:0] PK_C = 16'd0;
`endif

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [15:0] period;
    logic        cmp_wr_valid;
    logic        cmp_wr_ready;
    logic [47:0] cmp_wr_data;
    logic [15:0] carrier;
    logic [47:0] compare;
    logic [2:0]  pwm_onoff;
    logic        update_evt;
    logic        cnt_up;

    int          checks;
    int          errors;
    exp_t        exp_q[$];
    upd_t        upd_q[$];
    logic [47:0] exp_cmp;
    int          stalls;

    pwm_carrier_sched #(.N_CH(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .period       (period),
        .cmp_wr_valid (cmp_wr_valid),
        .cmp_wr_ready (cmp_wr_ready),
        .cmp_wr_data  (cmp_wr_data),
        .carrier      (carrier),
        .compare      (compare),
        .pwm_onoff    (pwm_onoff),
        .update_evt   (update_evt),
        .cnt_up       (cnt_up)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_e(input logic [15:0] c, input logic up, input logic [2:0] on);
        exp_t e;
        e.c  = c;
        e.up = up;
        e.on = on;
        exp_q.push_back(e);
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        upd_t u;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("carrier", 64'(carrier), 64'(e.c));
            check("cnt_up", 64'(cnt_up), 64'(e.up));
            check("pwm_onoff", 64'(pwm_onoff), 64'(e.on));
        end
        if (update_evt === 1'b1) begin
            check("update_expected", 64'(upd_q.size() != 0), 64'd1);
            if (upd_q.size() != 0) begin
                u = upd_q.pop_front();
                check("compare_at_update", 64'(compare), 64'(u.cmp));
                check("carrier_at_update", 64'(carrier), 64'(u.c));
                exp_cmp = u.cmp;
            end
        end else begin
            check("compare_held", 64'(compare), 64'(exp_cmp));
        end
    endtask

    // Offer one compare set, wait (bounded) for ready, queue its expected result.
    task automatic offer(input logic [47:0] d, input logic [47:0] expv,
                         input logic [15:0] upd_c, output int n_stall);
        upd_t u;
        cmp_wr_valid = 1'b1;
        cmp_wr_data  = d;
        n_stall      = 0;
        while (cmp_wr_ready !== 1'b1 && n_stall < 40) begin
            tick();
            n_stall++;
        end
        check("ready_before_accept", 64'(cmp_wr_ready), 64'd1);
        u.cmp = expv;
        u.c   = upd_c;
        upd_q.push_back(u);
        tick();
        cmp_wr_valid = 1'b0;
        check("ready_low_after_accept", 64'(cmp_wr_ready), 64'd0);
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (upd_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("update_applied", 64'(upd_q.size()), 64'd0);
    endtask

    task automatic wait_carrier(input logic [15:0] c, input logic up);
        int n;
        n = 0;
        while (!(carrier === c && cnt_up === up) && n < 40) begin
            tick();
            n++;
        end
        check("reach_carrier", 64'(carrier), 64'(c));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        exp_cmp      = 48'd0;
        rstn         = 1'b0;
        enable       = 1'b0;
        period       = 16'd4;
        cmp_wr_valid = 1'b0;
        cmp_wr_data  = 48'd0;

        // Reset values
        tick();
        tick();
        check("rst_carrier", 64'(carrier), 64'd0);
        check("rst_compare", 64'(compare), 64'd0);
        check("rst_onoff", 64'(pwm_onoff), 64'd0);
        check("rst_update_evt", 64'(update_evt), 64'd0);
        check("rst_cnt_up", 64'(cnt_up), 64'd1);
        check("rst_ready", 64'(cmp_wr_ready), 64'd1);

        // 1: start with period 4, one full triangle
        rstn   = 1'b1;
        enable = 1'b1;
        push_e(16'd0, 1'b1, 3'b111);
        push_e(16'd1, 1'b1, 3'b111);
        push_e(16'd2, 1'b1, 3'b111);
        push_e(16'd3, 1'b1, 3'b111);
        push_e(16'd4, 1'b0, 3'b111);
        push_e(16'd3, 1'b0, 3'b111);
        push_e(16'd2, 1'b0, 3'b111);
        push_e(16'd1, 1'b0, 3'b111);
        push_e(16'd0, 1'b1, 3'b111);
        while (exp_q.size() > 0) tick();

        // 2: write {3,2,1} at carrier 2 rising
        wait_carrier(16'd2, 1'b1);
        offer({16'd3, 16'd2, 16'd1}, {16'd3, 16'd2, 16'd1}, PK_C, stalls);
        wait_empty();
        check("t2_ready_after_update", 64'(cmp_wr_ready), 64'd1);
        check("t2_compare", 64'(compare), 64'({16'd3, 16'd2, 16'd1}));

        // 3: clamp to period
        wait_carrier(16'd0, 1'b1);
        offer({16'd9, 16'd9, 16'd9}, {16'd4, 16'd4, 16'd4}, PK_C, stalls);
        wait_empty();

        // 4: back-to-back writes, second stalls until the first is applied
        wait_carrier(16'd0, 1'b1);
        offer({16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd1}, PK_C, stalls);
        offer({16'd2, 16'd3, 16'd0}, {16'd2, 16'd3, 16'd0}, 16'd0, stalls);
        check("t4_second_stalled", 64'(stalls > 0), 64'd1);
        wait_empty();

        // 5: stop at carrier 3 rising, outputs drop at the valley
        wait_carrier(16'd3, 1'b1);
        enable = 1'b0;
        push_e(16'd4, 1'b0, 3'b111);
        push_e(16'd3, 1'b0, 3'b111);
        push_e(16'd2, 1'b0, 3'b111);
        push_e(16'd1, 1'b0, 3'b111);
        push_e(16'd0, 1'b1, 3'b000);
        push_e(16'd0, 1'b1, 3'b000);
        push_e(16'd0, 1'b1, 3'b000);
        while (exp_q.size() > 0) tick();

        // 6: restart, mid-period period change, write at carrier 1 rising
        period = 16'd4;
        enable = 1'b1;
        push_e(16'd0, 1'b1, 3'b111);
        push_e(16'd1, 1'b1, 3'b111);
        push_e(16'd2, 1'b1, 3'b111);
        push_e(16'd3, 1'b1, 3'b111);
        push_e(16'd4, 1'b0, 3'b111);
        push_e(16'd3, 1'b0, 3'b111);
        push_e(16'd2, 1'b0, 3'b111);
        push_e(16'd1, 1'b0, 3'b111);
        push_e(16'd0, 1'b1, 3'b111);
        push_e(16'd1, 1'b1, 3'b111);
        push_e(16'd2, 1'b0, 3'b111);
        push_e(16'd1, 1'b0, 3'b111);
        push_e(16'd0, 1'b1, 3'b111);
        tick();
        period = 16'd2;
        tick();
`ifdef PWM_PEAK_UPDATE_EN
        offer({16'd5, 16'd0, 16'd3}, {16'd4, 16'd0, 16'd3}, 16'd4, stalls);
`else
        offer({16'd5, 16'd0, 16'd3}, {16'd2, 16'd0, 16'd2}, 16'd0, stalls);
`endif
        while (exp_q.size() > 0) tick();
        check("t6_update_done", 64'(upd_q.size()), 64'd0);

        // period 0: carrier pinned at 0, every cycle a valley
        period = 16'd0;
        push_e(16'd1, 1'b1, 3'b111);
        push_e(16'd2, 1'b0, 3'b111);
        push_e(16'd1, 1'b0, 3'b111);
        push_e(16'd0, 1'b1, 3'b111);
        push_e(16'd0, 1'b1, 3'b111);
        push_e(16'd0, 1'b1, 3'b111);
        while (exp_q.size() > 0) tick();
        offer({16'd7, 16'd7, 16'd7}, {16'd0, 16'd0, 16'd0}, 16'd0, stalls);
        wait_empty();

        // Reset mid-run discards a pending shadow
        period = 16'd4;
        tick();
        tick();
        check("pre_reset_carrier", 64'(carrier), 64'd1);
        offer({16'd1, 16'd2, 16'd3}, {16'd1, 16'd2, 16'd3}, PK_C, stalls);
        rstn = 1'b0;
        upd_q.delete();
        exp_cmp = 48'd0;
        tick();
        check("mid_rst_carrier", 64'(carrier), 64'd0);
        check("mid_rst_ready", 64'(cmp_wr_ready), 64'd1);
        check("mid_rst_onoff", 64'(pwm_onoff), 64'd0);
        check("mid_rst_cnt_up", 64'(cnt_up), 64'd1);
        check("mid_rst_compare", 64'(compare), 64'd0);
        rstn = 1'b1;
        push_e(16'd0, 1'b1, 3'b111);
        push_e(16'd1, 1'b1, 3'b111);
        push_e(16'd2, 1'b1, 3'b111);
        push_e(16'd3, 1'b1, 3'b111);
        push_e(16'd4, 1'b0, 3'b111);
        push_e(16'd3, 1'b0, 3'b111);
        push_e(16'd2, 1'b0, 3'b111);
        push_e(16'd1, 1'b0, 3'b111);
        push_e(16'd0, 1'b1, 3'b111);
        while (exp_q.size() > 0) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
